// File: rtl/short_fifo_ex.sv
// short_fifo_ex -- parametrised valid/ready FIFO with occupancy count,
// programmable almost-full flag, synchronous flush and an optional
// registered output stage.
//
// Parameters
//   DATA_W  payload width in bits (>=1)
//   DEPTH   total capacity in entries, power of two, >=2
//   AF_LVL  almost_full asserts when count >= AF_LVL (1..DEPTH)
//
// Ports
//   clk          rising-edge clock for all state
//   rst          asynchronous active-high reset (assert async, release sync)
//   flush        synchronous clear; overrides any same-cycle write or read
//   wr_data      write payload
//   wr_valid     producer has data
//   wr_ready     FIFO can accept a word (count < DEPTH, out of reset, no flush)
//   rd_data      head-of-queue payload (meaningless while rd_valid=0)
//   rd_valid     head word is valid
//   rd_ready     consumer takes the head word
//   count        entries held, including the output stage when present
//   almost_full  count >= AF_LVL
//
// Build option
//   SHORT_FIFO_EX_OREG_EN  when defined, rd_data/rd_valid come straight from
//   flops (write-to-rd_valid latency 2 on an empty FIFO, rd_data resets to 0).
//   When undefined the head is read first-word-fall-through from the array
//   (latency 1). Capacity is DEPTH in both builds.

module short_fifo_ex #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AF_LVL = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LVL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic              live_q;
  logic              wr_en;
  logic              rd_en;
  logic              rd_adv;

  // live_q keeps wr_ready low while reset is held and opens it on the first
  // edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) live_q <= 1'b0;
    else     live_q <= 1'b1;
  end

  // Only registered state plus flush; rd_ready never reaches wr_ready, so a
  // read on a full FIFO re-opens the write side one cycle later.
  assign wr_ready = live_q & (count_q < FULL_CNT) & ~flush;
  assign wr_en    = wr_valid & wr_ready;
  assign rd_en    = rd_valid & rd_ready & ~flush;

  always_comb begin
    count_d = count_q;
    if (flush)
      count_d = '0;
    else if (wr_en && !rd_en)
      count_d = count_q + CNT_W'(1);
    else if (!wr_en && rd_en)
      count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q <= count_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (wr_en)  wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (rd_adv) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // Storage carries no reset; contents are qualified by count/valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= wr_data;
  end

`ifdef SHORT_FIFO_EX_OREG_EN
  logic              oreg_valid_q;
  logic [DATA_W-1:0] oreg_data_q;
  logic              arr_has_data;
  logic              oreg_load;

  // The array holds count minus the word parked in the output register.
  // Using the registered count means a word written this cycle is not yet
  // visible to the loader, which gives the two-cycle empty latency.
  assign arr_has_data = (count_q != CNT_W'(oreg_valid_q));
  assign oreg_load    = arr_has_data & (~oreg_valid_q | rd_en) & ~flush;
  assign rd_adv       = oreg_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oreg_valid_q <= 1'b0;
      oreg_data_q  <= '0;
    end else if (flush) begin
      oreg_valid_q <= 1'b0;
    end else if (oreg_load) begin
      oreg_valid_q <= 1'b1;
      oreg_data_q  <= mem[rd_ptr_q];
    end else if (rd_en) begin
      oreg_valid_q <= 1'b0;
    end
  end

  assign rd_valid = oreg_valid_q;
  assign rd_data  = oreg_data_q;
`else
  // First-word-fall-through: the head slot cannot be overwritten while it is
  // valid (that would need count==DEPTH, where wr_ready is low), so rd_data
  // holds steady under a stall.
  assign rd_adv   = rd_en;
  assign rd_valid = (count_q != '0);
  assign rd_data  = mem[rd_ptr_q];
`endif

  assign count       = count_q;
  assign almost_full = (count_q >= AF_CNT);

endmodule

// File: tb/tb_short_fifo_ex.sv
// Directed and randomised bench for short_fifo_ex (DATA_W=8, DEPTH=16,
// AF_LVL=12). Works with or without SHORT_FIFO_EX_OREG_EN defined.

module tb_short_fifo_ex;

`ifdef SHORT_FIFO_EX_OREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready = 1'b0;
  logic [4:0] count;
  logic       almost_full;

  short_fifo_ex #(.DATA_W(8), .DEPTH(16), .AF_LVL(12)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .count       (count),
    .almost_full (almost_full)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model
  logic [7:0] q[$];
  int         m_cnt = 0;
  logic       m_rv = 1'b0;
  logic       m_init = 1'b0;
  logic       stall_pend = 1'b0;
  logic [7:0] stall_data = 8'h00;
  logic [7:0] last_pre_data;
  int         n_reads = 0;

  typedef struct {
    logic       fl;
    logic       wv;
    logic [7:0] wd;
    logic       rr;
    int         e_cnt;
    logic       e_wrdy;
    logic       e_af;
    logic       chk_d;
    logic [7:0] e_data;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, check pre-edge outputs against the model,
  // update the model with what the edge must accept, return 1 ns after edge.
  task automatic cycle(input logic fl, input logic wv, input logic [7:0] wd, input logic rr);
    logic acc_w, acc_r;
    int   arr;
    @(negedge clk);
    flush = fl; wr_valid = wv; wr_data = wd; rd_ready = rr;
    #1;
    chk("count", count, m_cnt);
    chk("rd_valid", rd_valid, m_rv);
    chk("wr_ready", wr_ready, (m_init && m_cnt < 16 && !fl));
    chk("almost_full", almost_full, (m_cnt >= 12));
    if (stall_pend) chk("stall_data", rd_data, stall_data);
    last_pre_data = rd_data;
    acc_w = wv & m_init & (m_cnt < 16) & !fl;
    acc_r = m_rv & rr & !fl;
    stall_pend = m_rv & !rr & !fl;
    stall_data = rd_data;
    arr = m_cnt - int'(m_rv);
    if (acc_r) begin
      n_reads++;
      if (q.size() == 0) chk("underflow", 1, 0);
      else chk("rd_data", rd_data, q.pop_front());
    end
    if (fl) begin
      q.delete();
      m_cnt = 0;
      m_rv = 1'b0;
    end else begin
      if (acc_w) q.push_back(wd);
      m_cnt = m_cnt + int'(acc_w) - int'(acc_r);
`ifdef SHORT_FIFO_EX_OREG_EN
      m_rv = (m_rv & !acc_r) | (arr > 0);
`else
      m_rv = (m_cnt > 0);
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    #2;
    rst = 1'b1; flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
    #1;
    q.delete(); m_cnt = 0; m_rv = 1'b0; m_init = 1'b0; stall_pend = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_almost_full", almost_full, 0);
`ifdef SHORT_FIFO_EX_OREG_EN
    chk("rst_rd_data", rd_data, 0);
`endif
    repeat (hold) @(negedge clk);
    chk("rst_hold_wr_ready", wr_ready, 0);
    chk("rst_hold_count", count, 0);
    rst = 1'b0;
    #1;
    chk("release_wr_ready_pre", wr_ready, 0);
    @(posedge clk);
    #1;
    chk("release_wr_ready_edge", wr_ready, 1);
    m_init = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   r0;

    // fill 0x00..0x0F, one rejected write, drain in order
    for (int i = 0; i < 16; i++) begin
      v = '{fl:0, wv:1, wd:8'(i), rr:0, e_cnt:i+1, e_wrdy:(i+1 < 16),
            e_af:(i+1 >= 12), chk_d:0, e_data:8'h00};
      vecs.push_back(v);
    end
    v = '{fl:0, wv:1, wd:8'hEE, rr:0, e_cnt:16, e_wrdy:0, e_af:1, chk_d:0, e_data:8'h00};
    vecs.push_back(v);
    for (int i = 0; i < 16; i++) begin
      v = '{fl:0, wv:0, wd:8'h00, rr:1, e_cnt:15-i, e_wrdy:1,
            e_af:(15-i >= 12), chk_d:1, e_data:8'(i)};
      vecs.push_back(v);
    end

    do_reset(10);

    foreach (vecs[i]) begin
      cycle(vecs[i].fl, vecs[i].wv, vecs[i].wd, vecs[i].rr);
      chk("tbl_count", count, vecs[i].e_cnt);
      chk("tbl_wr_ready", wr_ready, vecs[i].e_wrdy);
      chk("tbl_almost_full", almost_full, vecs[i].e_af);
      if (vecs[i].chk_d) chk("tbl_rd_data", last_pre_data, vecs[i].e_data);
    end

    // write-to-read latency on an empty FIFO
    cycle(0, 1, 8'hA5, 0);
    chk("lat_first_rd_valid", rd_valid, (LAT == 1));
    cycle(0, 0, 8'h00, 0);
    chk("lat_second_rd_valid", rd_valid, 1);
    chk("lat_rd_data", rd_data, 8'hA5);
    cycle(0, 0, 8'h00, 1);
    chk("lat_drained", count, 0);
    cycle(0, 0, 8'h00, 0);

    // streaming: 100 words, one per cycle
    r0 = n_reads;
    for (int i = 0; i < 100; i++) begin
      cycle(0, 1, 8'(i + 8'h10), 1);
      if (i >= LAT) chk("stream_count", count, LAT);
    end
    for (int i = 0; i < 10 && m_cnt != 0; i++) cycle(0, 0, 8'h00, 1);
    chk("stream_reads", n_reads - r0, 100);
    chk("stream_empty", count, 0);

    // flush overrides simultaneous write and read
    for (int i = 0; i < 7; i++) cycle(0, 1, 8'(8'h50 + i), 0);
    cycle(0, 0, 8'h00, 0);
    chk("pre_flush_count", count, 7);
    cycle(1, 1, 8'h77, 1);
    chk("flush_count", count, 0);
    chk("flush_rd_valid", rd_valid, 0);
    cycle(0, 1, 8'h3C, 0);
    repeat (LAT - 1) cycle(0, 0, 8'h00, 0);
    chk("post_flush_rd_valid", rd_valid, 1);
    chk("post_flush_rd_data", rd_data, 8'h3C);
    cycle(0, 0, 8'h00, 1);
    chk("post_flush_count", count, 0);

    // random traffic with a mid-run asynchronous reset
    for (int c = 0; c < 2000; c++) begin
      if (c == 1000) do_reset(2);
      cycle(0, ($urandom_range(0, 99) < 60), 8'($urandom), ($urandom_range(0, 99) < 60));
    end
    for (int i = 0; i < 40 && m_cnt != 0; i++) cycle(0, 0, 8'h00, 1);
    chk("final_empty", count, 0);
    chk("final_queue_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
